dmem_arbiter: RTL

Two-port arbiter and sequencer that shares the single data memory between the CPU load/store port (port 0) and a DMA/debug port (port 1). It sits between the datapath's memory stage and the data memory. It grants one word access at a time, using round-robin on contention. It drives the memory's read/write strobes for exactly one cycle per access and returns read data with a one-cycle acknowledge pulse to the winning requester.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester identifiers and the default memory depth.
package dmem_arb_pkg;

    localparam int unsigned DEFAULT_WORDS = 8;
    localparam int unsigned DATA_W        = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: a lone requester always wins, and on
// contention the port that was not granted last takes the grant.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  port_id_t last_grant_i,
    output port_id_t grant_o,
    output logic     valid_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        grant_o = PORT0;
        if (req0_i && req1_i) begin
            grant_o = other_port(last_grant_i);
        end else if (req1_i) begin
            grant_o = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the CPU port (0) and the DMA/debug port (1):
// one word access per 3 cycles, one-cycle strobes, one-cycle ack to the winner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WORDS = DEFAULT_WORDS,
    parameter int unsigned AW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [AW-1:0]     addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AW-1:0]     addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    port_id_t          last_grant_q;
    port_id_t          lat_port_q;
    logic              lat_we_q;
    logic              lat_oor_q;

    logic              ack0_q, ack1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q, mem_write_q;

    port_id_t          grant;
    logic              grant_valid;

    logic              win_we;
    logic [AW-1:0]     win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_in_range;

    logic              capture_d;
    logic [DATA_W-1:0] resp_rdata_d;

    rr_arbiter2 u_rr (
        .req0_i       (req0),
        .req1_i       (req1),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .valid_o      (grant_valid)
    );

    always_comb begin
        win_we    = we0;
        win_addr  = addr0;
        win_wdata = wdata0;
        if (grant == PORT1) begin
            win_we    = we1;
            win_addr  = addr1;
            win_wdata = wdata1;
        end
        win_in_range = (win_addr < AW'(WORDS));
    end

    // Reads and out-of-range accesses both overwrite the winner's rdata;
    // an in-range write leaves the previous read value in place.
    always_comb begin
        capture_d    = lat_oor_q | ~lat_we_q;
        resp_rdata_d = lat_oor_q ? '0 : mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= PORT1;
            lat_port_q   <= PORT0;
            lat_we_q     <= 1'b0;
            lat_oor_q    <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        lat_port_q  <= grant;
                        lat_we_q    <= win_we;
                        lat_oor_q   <= ~win_in_range;
                        // Bus and strobes are registered here so they are
                        // valid for exactly the ACCESS cycle.
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= win_wdata;
                        mem_write_q <= win_in_range & win_we;
                        mem_read_q  <= win_in_range & ~win_we;
                        state_q     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (lat_port_q == PORT0) begin
                        ack0_q <= 1'b1;
                        err0_q <= lat_oor_q;
                        if (capture_d) begin
                            rdata0_q <= resp_rdata_d;
                        end
                    end else begin
                        ack1_q <= 1'b1;
                        err1_q <= lat_oor_q;
                        if (capture_d) begin
                            rdata1_q <= resp_rdata_d;
                        end
                    end
                    state_q <= ST_RESP;
                end

                ST_RESP: begin
                    last_grant_q <= lat_port_q;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule
